// File: rtl/spi_device_core.sv
// SPI device (slave) endpoint: register-bus front end, oversampled SPI pins,
// single-character TX/RX holding registers, sticky error flags and level interrupt.
module spi_device_core #(
    parameter int MAX_CHAR    = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [7:0]  addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    input  logic [3:0]  be_i,
    input  logic        we_i,
    input  logic        re_i,
    output logic        error_o,
    output logic        intr_o,
    input  logic        ss_ni,
    input  logic        sclk_i,
    input  logic        sd_i,
    output logic        sd_o,
    output logic        sd_oe_o
);
    localparam int CW = $clog2(MAX_CHAR + 1);

    typedef enum logic {IDLE, ACTIVE} state_e;

    typedef struct packed {
        logic       ie;
        logic       lsb;
        logic       tx_neg;
        logic       rx_neg;
        logic       en;
        logic [4:0] char_len;
    } ctrl_t;

    state_e                state_q, state_d;
    ctrl_t                 ctrl_q, ctrl_d;
    logic [31:0]           rx_q, rx_d;
    logic [MAX_CHAR-1:0]   tx_hold_q, tx_hold_d;
    logic [MAX_CHAR-1:0]   tx_shift_q, tx_shift_d;
    logic [MAX_CHAR-1:0]   rx_shift_q, rx_shift_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  tx_empty_q, tx_empty_d;
    logic                  overrun_q, overrun_d;
    logic                  underrun_q, underrun_d;
    logic                  pend_load_q, pend_load_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  intr_q, intr_d;
    logic [SYNC_STAGES:0]  ss_sync_q;
    logic [SYNC_STAGES:0]  sclk_sync_q;
    logic [SYNC_STAGES-1:0] sd_sync_q;

    logic                ss_active, ss_fall, sclk_rise, sclk_fall, sd_s;
    logic                sample_edge, shift_edge, busy;
    logic [CW-1:0]       char_len_eff, cnt_inc;
    logic [2:0]          reg_sel;
    logic                rx_rd, char_done;
    logic [MAX_CHAR-1:0] rx_next, rx_char;
    logic                unused_addr;

    // Edges come from the last synchronized stage versus one further delayed copy.
    assign ss_active   = ~ss_sync_q[SYNC_STAGES-1];
    assign ss_fall     = ~ss_sync_q[SYNC_STAGES-1] & ss_sync_q[SYNC_STAGES];
    assign sclk_rise   = sclk_sync_q[SYNC_STAGES-1] & ~sclk_sync_q[SYNC_STAGES];
    assign sclk_fall   = ~sclk_sync_q[SYNC_STAGES-1] & sclk_sync_q[SYNC_STAGES];
    assign sd_s        = sd_sync_q[SYNC_STAGES-1];
    assign sample_edge = ctrl_q.rx_neg ? sclk_fall : sclk_rise;
    assign shift_edge  = ctrl_q.tx_neg ? sclk_fall : sclk_rise;
    assign busy        = ss_active & ctrl_q.en;

    assign char_len_eff = (ctrl_q.char_len == 5'd0) ? CW'(MAX_CHAR) : CW'(ctrl_q.char_len);
    assign cnt_inc      = cnt_q + CW'(1);

    assign reg_sel     = addr_i[4:2];
    assign error_o     = (we_i | re_i) & reg_sel[2];
    assign unused_addr = ^{addr_i[7:5], addr_i[1:0]};
    assign rx_rd       = re_i && (reg_sel == 3'd0);

    // MSB-first characters are left-aligned so the outgoing bit is always the top bit.
    function automatic logic [MAX_CHAR-1:0] tx_load(input logic [MAX_CHAR-1:0] hold,
                                                    input logic empty, input logic lsb,
                                                    input logic [CW-1:0] len);
        if (empty) return '0;
        if (lsb) return hold;
        return hold << (CW'(MAX_CHAR) - len);
    endfunction

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path infers a latch.
        state_d     = state_q;
        ctrl_d      = ctrl_q;
        rx_d        = rx_q;
        tx_hold_d   = tx_hold_q;
        tx_shift_d  = tx_shift_q;
        rx_shift_d  = rx_shift_q;
        cnt_d       = cnt_q;
        rx_valid_d  = rx_valid_q;
        tx_empty_d  = tx_empty_q;
        overrun_d   = overrun_q;
        underrun_d  = underrun_q;
        pend_load_d = pend_load_q;
        rdata_d     = rdata_q;
        char_done   = 1'b0;
        rx_next     = ctrl_q.lsb ? {sd_s, rx_shift_q[MAX_CHAR-1:1]}
                                 : {rx_shift_q[MAX_CHAR-2:0], sd_s};
        rx_char     = ctrl_q.lsb ? (rx_next >> (CW'(MAX_CHAR) - char_len_eff)) : rx_next;

        // Clears are applied before the sets below so a coincident set wins.
        if (rx_rd) rx_valid_d = 1'b0;
        if (we_i && reg_sel == 3'd3 && be_i[0]) begin
            if (wdata_i[2]) overrun_d  = 1'b0;
            if (wdata_i[3]) underrun_d = 1'b0;
        end
        if (we_i && reg_sel == 3'd2 && !busy) begin
            if (be_i[0]) ctrl_d.char_len = wdata_i[4:0];
            if (be_i[1]) begin
                ctrl_d.en     = wdata_i[8];
                ctrl_d.rx_neg = wdata_i[9];
                ctrl_d.tx_neg = wdata_i[10];
                ctrl_d.lsb    = wdata_i[11];
                ctrl_d.ie     = wdata_i[12];
            end
        end

        case (state_q)
            IDLE: begin
                if (ss_fall && ctrl_q.en) begin
                    state_d     = ACTIVE;
                    tx_shift_d  = tx_load(tx_hold_q, tx_empty_q, ctrl_q.lsb, char_len_eff);
                    tx_empty_d  = 1'b1;
                    if (tx_empty_q) underrun_d = 1'b1;
                    cnt_d       = '0;
                    rx_shift_d  = '0;
                    pend_load_d = 1'b0;
                end
            end
            ACTIVE: begin
                if (!ss_active) begin
                    state_d     = IDLE;
                    cnt_d       = '0;
                    rx_shift_d  = '0;
                    pend_load_d = 1'b0;
                end else begin
                    if (sample_edge) begin
                        if (cnt_inc == char_len_eff) begin
                            char_done   = 1'b1;
                            cnt_d       = '0;
                            rx_shift_d  = '0;
                            pend_load_d = 1'b1;
                        end else begin
                            cnt_d      = cnt_inc;
                            rx_shift_d = rx_next;
                        end
                    end
                    if (shift_edge) begin
                        if (pend_load_q) begin
                            tx_shift_d  = tx_load(tx_hold_q, tx_empty_q, ctrl_q.lsb, char_len_eff);
                            tx_empty_d  = 1'b1;
                            if (tx_empty_q) underrun_d = 1'b1;
                            pend_load_d = 1'b0;
                        end else begin
                            tx_shift_d = ctrl_q.lsb ? (tx_shift_q >> 1) : (tx_shift_q << 1);
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (char_done) begin
            if (rx_valid_q && !rx_rd) begin
                overrun_d = 1'b1;
            end else begin
                rx_d       = 32'(rx_char);
                rx_valid_d = 1'b1;
            end
        end

        // A TX write after a reload in the same cycle still lands in the holding register.
        if (we_i && reg_sel == 3'd1 && (|be_i) && tx_empty_q) begin
            tx_hold_d  = wdata_i[MAX_CHAR-1:0];
            tx_empty_d = 1'b0;
        end

        if (re_i) begin
            case (reg_sel)
                3'd0:    rdata_d = rx_q;
                3'd2:    rdata_d = {19'b0, ctrl_q.ie, ctrl_q.lsb, ctrl_q.tx_neg, ctrl_q.rx_neg,
                                    ctrl_q.en, 3'b0, ctrl_q.char_len};
                3'd3:    rdata_d = {27'b0, busy, underrun_q, overrun_q, tx_empty_q, rx_valid_q};
                default: rdata_d = '0;
            endcase
        end

        intr_d = ctrl_q.ie & (rx_valid_q | overrun_q | underrun_q);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            ctrl_q      <= '0;
            rx_q        <= '0;
            tx_hold_q   <= '0;
            tx_shift_q  <= '0;
            rx_shift_q  <= '0;
            cnt_q       <= '0;
            rx_valid_q  <= 1'b0;
            tx_empty_q  <= 1'b1;
            overrun_q   <= 1'b0;
            underrun_q  <= 1'b0;
            pend_load_q <= 1'b0;
            rdata_q     <= '0;
            intr_q      <= 1'b0;
            ss_sync_q   <= '1;
            sclk_sync_q <= '0;
            sd_sync_q   <= '0;
        end else begin
            state_q     <= state_d;
            ctrl_q      <= ctrl_d;
            rx_q        <= rx_d;
            tx_hold_q   <= tx_hold_d;
            tx_shift_q  <= tx_shift_d;
            rx_shift_q  <= rx_shift_d;
            cnt_q       <= cnt_d;
            rx_valid_q  <= rx_valid_d;
            tx_empty_q  <= tx_empty_d;
            overrun_q   <= overrun_d;
            underrun_q  <= underrun_d;
            pend_load_q <= pend_load_d;
            rdata_q     <= rdata_d;
            intr_q      <= intr_d;
            ss_sync_q   <= {ss_sync_q[SYNC_STAGES-1:0], ss_ni};
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-1:0], sclk_i};
            sd_sync_q   <= {sd_sync_q[SYNC_STAGES-2:0], sd_i};
        end
    end

    assign rdata_o = rdata_q;
    assign intr_o  = intr_q;
    assign sd_oe_o = (state_q == ACTIVE);
    assign sd_o    = sd_oe_o & (ctrl_q.lsb ? tx_shift_q[0] : tx_shift_q[MAX_CHAR-1]);

endmodule

// File: tb/tb_spi_device_core.sv
// Self-checking bench for spi_device_core: register-access vector table plus
// SPI master sequences, with bus reads and MISO characters scored through queues.
module tb_spi_device_core;
    localparam int H = 8;  // clk_i cycles per sclk half period

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  be;
    logic        we, re, err, intr;
    logic        ss_n, sclk, sd_in, sd_out, sd_oe;

    int n_vec  = 0;
    int n_fail = 0;
    logic [31:0] rd_q[$];
    logic [31:0] spi_q[$];

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        we;
        logic        re;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t tbl[16];

    always #5 clk = ~clk;

    spi_device_core dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .addr_i  (addr),
        .wdata_i (wdata),
        .rdata_o (rdata),
        .be_i    (be),
        .we_i    (we),
        .re_i    (re),
        .error_o (err),
        .intr_o  (intr),
        .ss_ni   (ss_n),
        .sclk_i  (sclk),
        .sd_i    (sd_in),
        .sd_o    (sd_out),
        .sd_oe_o (sd_oe)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic bus(input string name, input logic [7:0] a, input logic [31:0] d,
                       input logic [3:0] b, input logic w, input logic r,
                       input logic [31:0] exp_rd, input logic exp_err);
        @(negedge clk);
        addr = a; wdata = d; be = b; we = w; re = r;
        #1;
        check({name, ".err"}, 32'(err), 32'(exp_err));
        if (r) rd_q.push_back(exp_rd);
        @(negedge clk);
        we = 1'b0; re = 1'b0; be = 4'h0;
        if (r) check(name, rdata, rd_q.pop_front());
    endtask

    task automatic wr(input string name, input logic [7:0] a, input logic [31:0] d, input logic [3:0] b);
        bus(name, a, d, b, 1'b1, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic rd(input string name, input logic [7:0] a, input logic [31:0] exp);
        bus(name, a, 32'h0, 4'h0, 1'b0, 1'b1, exp, 1'b0);
    endtask

    task automatic ss_low(input string name);
        ss_n = 1'b0;
        repeat (H) @(negedge clk);
        check(name, 32'(sd_oe), 32'h1);
    endtask

    task automatic ss_high();
        repeat (H) @(negedge clk);
        ss_n = 1'b1;
        repeat (2 * H) @(negedge clk);
    endtask

    // Mode-0 style master: drive MOSI while sclk is low, sample MISO on the rising edge.
    task automatic spi_char(input string name, input logic [31:0] mosi, input int nbits,
                            input bit lsb, input logic [31:0] exp_miso);
        logic [31:0] miso;
        miso = '0;
        spi_q.push_back(exp_miso);
        for (int i = 0; i < nbits; i++) begin
            sd_in = lsb ? mosi[i] : mosi[nbits-1-i];
            repeat (H) @(negedge clk);
            sclk = 1'b1;
            if (lsb) miso[i] = sd_out;
            else     miso = {miso[30:0], sd_out};
            repeat (H) @(negedge clk);
            sclk = 1'b0;
        end
        check(name, miso, spi_q.pop_front());
    endtask

    initial begin
        #1_000_000;
        n_fail++;
        $display("FAIL watchdog: got timeout, want completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        //          addr   wdata         be    we    re    exp_rd        err
        tbl[0]  = '{8'h0C, 32'h0,        4'h0, 1'b0, 1'b1, 32'h00000002, 1'b0};
        tbl[1]  = '{8'h08, 32'h0,        4'h0, 1'b0, 1'b1, 32'h00000000, 1'b0};
        tbl[2]  = '{8'h08, 32'h00001F3F, 4'h1, 1'b1, 1'b0, 32'h0,        1'b0};
        tbl[3]  = '{8'h08, 32'h0,        4'h0, 1'b0, 1'b1, 32'h0000001F, 1'b0};
        tbl[4]  = '{8'h08, 32'hFFFFFF08, 4'h2, 1'b1, 1'b0, 32'h0,        1'b0};
        tbl[5]  = '{8'h08, 32'h0,        4'h0, 1'b0, 1'b1, 32'h00001F1F, 1'b0};
        tbl[6]  = '{8'h08, 32'h00000000, 4'h3, 1'b1, 1'b0, 32'h0,        1'b0};
        tbl[7]  = '{8'h08, 32'h0,        4'h0, 1'b0, 1'b1, 32'h00000000, 1'b0};
        tbl[8]  = '{8'h04, 32'h0,        4'h0, 1'b0, 1'b1, 32'h00000000, 1'b0};
        tbl[9]  = '{8'h04, 32'h000000EE, 4'h0, 1'b1, 1'b0, 32'h0,        1'b0};
        tbl[10] = '{8'h0C, 32'h0,        4'h0, 1'b0, 1'b1, 32'h00000002, 1'b0};
        tbl[11] = '{8'h1C, 32'h0,        4'h0, 1'b0, 1'b1, 32'h00000000, 1'b1};
        tbl[12] = '{8'h14, 32'hFFFFFFFF, 4'hF, 1'b1, 1'b0, 32'h0,        1'b1};
        tbl[13] = '{8'h10, 32'h0,        4'h0, 1'b0, 1'b1, 32'h00000000, 1'b1};
        tbl[14] = '{8'h0C, 32'h0,        4'h0, 1'b0, 1'b1, 32'h00000002, 1'b0};
        tbl[15] = '{8'h00, 32'h0,        4'h0, 1'b0, 1'b1, 32'h00000000, 1'b0};

        rst = 1'b1; addr = '0; wdata = '0; be = '0; we = 1'b0; re = 1'b0;
        ss_n = 1'b1; sclk = 1'b0; sd_in = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst.rdata", rdata, 32'h0);
        check("rst.intr", 32'(intr), 32'h0);
        check("rst.sd_o", 32'(sd_out), 32'h0);
        check("rst.sd_oe", 32'(sd_oe), 32'h0);
        check("rst.err", 32'(err), 32'h0);

        for (int i = 0; i < 16; i++)
            bus($sformatf("vec%0d", i), tbl[i].addr, tbl[i].wdata, tbl[i].be,
                tbl[i].we, tbl[i].re, tbl[i].exp_rd, tbl[i].exp_err);

        // Mode 0, 8-bit, TX=0xA5, master sends 0x3C; trailing shift edge reloads an empty TX.
        wr("s1.ctrl", 8'h08, 32'h00001508, 4'h3);
        wr("s1.tx", 8'h04, 32'h000000A5, 4'h1);
        rd("s1.stat0", 8'h0C, 32'h00000000);
        ss_low("s1.oe");
        spi_char("s1.miso", 32'h3C, 8, 1'b0, 32'hA5);
        ss_high();
        check("s1.oe_idle", 32'(sd_oe), 32'h0);
        rd("s1.stat1", 8'h0C, 32'h0000000B);
        check("s1.intr", 32'(intr), 32'h1);
        rd("s1.rx", 8'h00, 32'h0000003C);
        rd("s1.stat2", 8'h0C, 32'h0000000A);
        wr("s1.w1c", 8'h0C, 32'h00000008, 4'h1);
        rd("s1.stat3", 8'h0C, 32'h00000002);
        check("s1.intr_clr", 32'(intr), 32'h0);

        // Back-to-back characters without an RX read.
        wr("s2.tx", 8'h04, 32'h00000011, 4'h1);
        ss_low("s2.oe");
        spi_char("s2.miso0", 32'h5A, 8, 1'b0, 32'h11);
        spi_char("s2.miso1", 32'hC3, 8, 1'b0, 32'h00);
        ss_high();
        rd("s2.stat0", 8'h0C, 32'h0000000F);
        check("s2.intr", 32'(intr), 32'h1);
        wr("s2.w1c_ovr", 8'h0C, 32'h00000004, 4'h1);
        rd("s2.stat1", 8'h0C, 32'h0000000B);
        rd("s2.rx", 8'h00, 32'h0000005A);
        rd("s2.stat2", 8'h0C, 32'h0000000A);
        wr("s2.w1c_und", 8'h0C, 32'h00000008, 4'h1);
        rd("s2.stat3", 8'h0C, 32'h00000002);

        // Underrun at entry; a TX write during the first character feeds the second.
        ss_low("s3.oe");
        fork
            begin
                spi_char("s3.miso0", 32'h77, 8, 1'b0, 32'h00);
                spi_char("s3.miso1", 32'h22, 8, 1'b0, 32'h96);
            end
            begin
                repeat (20) @(negedge clk);
                rd("s3.stat_busy", 8'h0C, 32'h0000001A);
                wr("s3.tx", 8'h04, 32'h00000096, 4'h1);
            end
        join
        ss_high();
        rd("s3.stat0", 8'h0C, 32'h0000000F);
        rd("s3.rx", 8'h00, 32'h00000077);
        wr("s3.w1c", 8'h0C, 32'h0000000C, 4'h1);
        rd("s3.stat1", 8'h0C, 32'h00000002);

        // LSB first, 32-bit characters.
        wr("s4.ctrl", 8'h08, 32'h00001D00, 4'h3);
        rd("s4.ctrl_rb", 8'h08, 32'h00001D00);
        wr("s4.tx", 8'h04, 32'h12345678, 4'hF);
        ss_low("s4.oe");
        spi_char("s4.miso", 32'hDEADBEEF, 32, 1'b1, 32'h12345678);
        ss_high();
        rd("s4.rx", 8'h00, 32'hDEADBEEF);
        rd("s4.stat0", 8'h0C, 32'h0000000A);
        wr("s4.w1c", 8'h0C, 32'h00000008, 4'h1);

        // CTRL locked while busy; aborted partial character leaves no stale bits.
        wr("s5.ctrl", 8'h08, 32'h00001508, 4'h3);
        wr("s5.tx", 8'h04, 32'h000000F0, 4'h1);
        ss_low("s5.oe");
        wr("s5.ctrl_busy", 8'h08, 32'h00000000, 4'h3);
        rd("s5.ctrl_rb", 8'h08, 32'h00001508);
        rd("s5.stat_busy", 8'h0C, 32'h00000012);
        spi_char("s5.partial", 32'h1F, 5, 1'b0, 32'h1E);
        ss_high();
        check("s5.oe_idle", 32'(sd_oe), 32'h0);
        check("s5.sd_idle", 32'(sd_out), 32'h0);
        rd("s5.stat0", 8'h0C, 32'h00000002);
        wr("s5.tx2", 8'h04, 32'h0000003C, 4'h1);
        ss_low("s5.oe2");
        spi_char("s5.miso", 32'h81, 8, 1'b0, 32'h3C);
        ss_high();
        rd("s5.stat1", 8'h0C, 32'h0000000B);
        rd("s5.rx", 8'h00, 32'h00000081);
        wr("s5.w1c", 8'h0C, 32'h00000008, 4'h1);

        // Reset in the middle of a character.
        ss_low("s6.oe");
        spi_char("s6.partial", 32'hA, 4, 1'b0, 32'h0);
        check("s6.intr_pre", 32'(intr), 32'h1);
        rd("s6.ctrl_pre", 8'h08, 32'h00001508);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("s6.rdata", rdata, 32'h0);
        check("s6.intr", 32'(intr), 32'h0);
        check("s6.sd_oe", 32'(sd_oe), 32'h0);
        check("s6.sd_o", 32'(sd_out), 32'h0);
        ss_n = 1'b1;
        repeat (2 * H) @(negedge clk);
        rd("s6.stat", 8'h0C, 32'h00000002);
        rd("s6.ctrl", 8'h08, 32'h00000000);
        rd("s6.rx", 8'h00, 32'h00000000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
